// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared width, op encodings and FSM states for shift_sequencer
// Purpose: common definitions imported by shifter and shift_sequencer.
// Contents: W (register width), op_e (step operation), state_e (sequencer FSM).
package shift_sequencer_pkg;

  localparam int W = 4;

  // Step operation, encoded as {s1,s0}
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_ROT  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// rtl/shift_sequencer_shifter.sv - combinational one-step 4-bit shifter
// Purpose: applies one hold / shift-left / shift-right / rotate-left step.
// Ports:
//   i3..i0  in   current value, i3 = MSB
//   s1,s0   in   operation select {s1,s0} (see op_e)
//   d3..d0  out  value after one step, d3 = MSB
module shifter
  import shift_sequencer_pkg::*;
(
  input  logic i3,
  input  logic i2,
  input  logic i1,
  input  logic i0,
  input  logic s1,
  input  logic s0,
  output logic d3,
  output logic d2,
  output logic d1,
  output logic d0
);

  logic [3:0] w_in;
  logic [3:0] w_out;
  op_e        w_op;

  assign w_in = {i3, i2, i1, i0};
  assign w_op = op_e'({s1, s0});

  always_comb begin
    w_out = w_in;
    case (w_op)
      OP_HOLD: w_out = w_in;
      OP_SHL:  w_out = {w_in[2:0], 1'b0};
      OP_SHR:  w_out = {1'b0, w_in[3:1]};
      OP_ROT:  w_out = {w_in[2:0], w_in[3]};
      default: w_out = w_in;
    endcase
  end

  assign {d3, d2, d1, d0} = w_out;

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - load / run-N-steps / done sequencer around the shifter
// Purpose: holds a 4-bit register, loads it in IDLE, and on start applies a latched
//          op for count steps, then pulses done for one cycle.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   load    in   parallel load request (IDLE only, wins over start)
//   ld_val  in   parallel load data
//   start   in   start request (IDLE only)
//   op      in   step operation {s1,s0}
//   count   in   number of steps 0..7
//   q       out  registered value
//   busy    out  high in RUN and DONE
//   done    out  high for the single DONE cycle
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [2:0]   count,
  output logic [W-1:0] q,
  output logic         busy,
  output logic         done
);

  state_e       r_state;
  logic [W-1:0] r_q;
  logic [2:0]   r_cnt;
  op_e          r_op;
  logic [W-1:0] w_d;

  // Feedback path: the register always drives the shifter, the latched op selects the step
  shifter u_shifter (
    .i3 (r_q[3]),
    .i2 (r_q[2]),
    .i1 (r_q[1]),
    .i0 (r_q[0]),
    .s1 (r_op[1]),
    .s0 (r_op[0]),
    .d3 (w_d[3]),
    .d2 (w_d[2]),
    .d1 (w_d[1]),
    .d0 (w_d[0])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_cnt   <= 3'd0;
      r_op    <= OP_HOLD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_q <= ld_val;
          end else if (start) begin
            if (count != 3'd0) begin
              r_op    <= op_e'(op);
              r_cnt   <= count;
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          r_q   <= w_d;
          r_cnt <= r_cnt - 3'd1;
          // r_cnt still holds the steps remaining before this edge
          if (r_cnt == 3'd1) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign q    = r_q;
  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer
module tb_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] ld_val;
  logic       start;
  logic [1:0] op;
  logic [2:0] count;
  logic [3:0] q;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  // Expected {q, done} for each busy cycle, in order
  logic [4:0] sb[$];

  shift_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .ld_val (ld_val),
    .start  (start),
    .op     (op),
    .count  (count),
    .q      (q),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: every busy cycle must match the next scoreboard entry
  always @(negedge clk) begin
    if (!rst && busy) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got q=%b done=%b expected no busy cycle", q, done);
      end else begin
        logic [4:0] e;
        e = sb.pop_front();
        chk("sb_q_done", {3'b0, q, done}, {3'b0, e});
      end
    end
  end

  task automatic do_load(input logic [3:0] v);
    @(posedge clk); #1;
    load = 1'b1; ld_val = v;
    @(posedge clk); #1;
    load = 1'b0; ld_val = 4'b0000;
    chk("load_q", {4'b0, q}, {4'b0, v});
  endtask

  // Issued right after a posedge; returns right after the start edge
  task automatic do_start(input logic [1:0] o, input logic [2:0] c);
    start = 1'b1; op = o; count = c;
    @(posedge clk); #1;
    start = 1'b0; op = 2'b00; count = 3'd5;
  endtask

  task automatic wait_idle(input string nm);
    logic to;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
    chk({nm, "_timeout"}, {7'b0, to}, 8'd0);
    chk({nm, "_drained"}, sb.size(), 8'd0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; ld_val = 4'b0; start = 1'b0; op = 2'b00; count = 3'd0;
    #12;
    chk("rst_q", {4'b0, q}, 8'd0);
    chk("rst_busy", {7'b0, busy}, 8'd0);
    chk("rst_done", {7'b0, done}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Shift left once
    do_load(4'b1011);
    sb.push_back({4'b1011, 1'b0});
    sb.push_back({4'b0110, 1'b1});
    do_start(2'b01, 3'd1);
    wait_idle("shl1");
    chk("shl1_q", {4'b0, q}, {4'b0, 4'b0110});

    // Rotate left four times; a load/start/op change during RUN must be ignored
    do_load(4'b1001);
    sb.push_back({4'b1001, 1'b0});
    sb.push_back({4'b0011, 1'b0});
    sb.push_back({4'b0110, 1'b0});
    sb.push_back({4'b1100, 1'b0});
    sb.push_back({4'b1001, 1'b1});
    do_start(2'b11, 3'd4);
    load = 1'b1; ld_val = 4'b0000; start = 1'b1; op = 2'b10; count = 3'd7;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    wait_idle("rot4");
    chk("rot4_q", {4'b0, q}, {4'b0, 4'b1001});

    // Shift right three times, then hold in IDLE
    do_load(4'b1111);
    sb.push_back({4'b1111, 1'b0});
    sb.push_back({4'b0111, 1'b0});
    sb.push_back({4'b0011, 1'b0});
    sb.push_back({4'b0001, 1'b1});
    do_start(2'b10, 3'd3);
    wait_idle("shr3");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("shr3_hold_q", {4'b0, q}, {4'b0, 4'b0001});

    // Hold op for two steps
    do_load(4'b0110);
    sb.push_back({4'b0110, 1'b0});
    sb.push_back({4'b0110, 1'b0});
    sb.push_back({4'b0110, 1'b1});
    do_start(2'b00, 3'd2);
    wait_idle("hold2");

    // count=0 goes straight to DONE
    do_load(4'b0101);
    sb.push_back({4'b0101, 1'b1});
    do_start(2'b01, 3'd0);
    wait_idle("cnt0");
    chk("cnt0_q", {4'b0, q}, {4'b0, 4'b0101});

    // load and start together: load wins, no operation
    do_load(4'b1100);
    @(posedge clk); #1;
    load = 1'b1; ld_val = 4'b0011; start = 1'b1; op = 2'b01; count = 3'd3;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    chk("ldst_q", {4'b0, q}, {4'b0, 4'b0011});
    chk("ldst_busy", {7'b0, busy}, 8'd0);
    @(posedge clk); #1;
    chk("ldst_busy2", {7'b0, busy}, 8'd0);
    chk("ldst_done2", {7'b0, done}, 8'd0);

    // Reset mid-RUN: rotate 1000 by 7, abort after two steps
    do_load(4'b1000);
    sb.push_back({4'b1000, 1'b0});
    sb.push_back({4'b0001, 1'b0});
    sb.push_back({4'b0010, 1'b0});
    do_start(2'b11, 3'd7);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    chk("abort_drained", sb.size(), 8'd0);
    rst = 1'b1;
    #1;
    chk("abort_q", {4'b0, q}, 8'd0);
    chk("abort_busy", {7'b0, busy}, 8'd0);
    chk("abort_done", {7'b0, done}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_done_post", {7'b0, done}, 8'd0);
    // First edge after reset release accepts a load
    do_load(4'b1010);
    chk("post_rst_busy", {7'b0, busy}, 8'd0);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish expected finish before 50000");
    $fatal(1);
  end

endmodule
